// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and hazard_ctrl.
// master: pipeline side (drives stage info, receives controls).
// slave : hazard_ctrl side (receives stage info, drives controls).
// Signals:
//   ID/EX/MEM/WB register ids and write flags, load flag, branch resolution
//   and BTB prediction, data-memory request/ready handshake;
//   pipeline write enables, flushes, PC redirect, forwarding selects and
//   the sticky memory watchdog error.
interface hazard_ctrl_if;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [4:0]  rs1E;
  logic [4:0]  rs2E;
  logic [4:0]  rdE;
  logic        mem_readE;
  logic [31:0] pcE;
  logic        branch_validE;
  logic        actual_takenE;
  logic [31:0] actual_targetE;
  logic        btb_predict_takenE;
  logic [31:0] btb_targetE;
  logic [4:0]  rdM;
  logic        reg_writeM;
  logic [4:0]  rdW;
  logic        reg_writeW;
  logic        mem_reqM;
  logic        mem_readyM;

  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  forward_aE;
  logic [1:0]  forward_bE;
  logic        mem_timeout;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, mem_readE, pcE,
    output branch_validE, actual_takenE, actual_targetE,
    output btb_predict_takenE, btb_targetE,
    output rdM, reg_writeM, rdW, reg_writeW, mem_reqM, mem_readyM,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_flush, mem_wb_flush,
    input  redirect_valid, redirect_pc, forward_aE, forward_bE, mem_timeout
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, mem_readE, pcE,
    input  branch_validE, actual_takenE, actual_targetE,
    input  btb_predict_takenE, btb_targetE,
    input  rdM, reg_writeM, rdW, reg_writeW, mem_reqM, mem_readyM,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_flush, mem_wb_flush,
    output redirect_valid, redirect_pc, forward_aE, forward_bE, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Produces pipeline-register write enables/flushes, the PC redirect on BTB
// mispredict, EX-stage forwarding selects, and freezes the pipe while a
// data-memory access is outstanding (RUN/MEM_WAIT FSM with watchdog).
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   hz (slave)  : hazard_ctrl_if bundle, see rtl/hazard_ctrl_if.sv
//   perf_*      : saturating event counters, present only with HAZARD_PERF_EN
// Config macro: HAZARD_PERF_EN adds perf_stall_cycles, perf_flush_count and
// perf_loaduse_count.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [31:0]   perf_flush_count,
  output logic [31:0]   perf_loaduse_count
`endif
);

  localparam logic [15:0] TimeoutCnt = 16'(MEM_TIMEOUT);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e      state_q;
  logic [15:0] wait_cnt_q;
  logic        timeout_q;

  logic        stall;
  logic        mispredict;
  logic        load_use;
  logic [31:0] pc_plus4;

  assign pc_plus4   = hz.pcE + 32'd4;
  assign stall      = hz.mem_reqM & ~hz.mem_readyM;
  assign mispredict = hz.branch_validE &
                      ((hz.actual_takenE != hz.btb_predict_takenE) |
                       (hz.actual_takenE & hz.btb_predict_takenE &
                        (hz.actual_targetE != hz.btb_targetE)));
  assign load_use   = hz.mem_readE & (hz.rdE != 5'd0) &
                      ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));

  // The FSM only drives the watchdog; outputs follow the stall term directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (stall) begin
            state_q    <= StMemWait;
            wait_cnt_q <= 16'd0;
          end
        end
        StMemWait: begin
          if (wait_cnt_q != 16'hFFFF) wait_cnt_q <= wait_cnt_q + 16'd1;
          if (wait_cnt_q + 16'd1 == TimeoutCnt) timeout_q <= 1'b1;
          if (hz.mem_readyM) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    hz.pc_write       = 1'b1;
    hz.if_id_write    = 1'b1;
    hz.id_ex_write    = 1'b1;
    hz.ex_mem_write   = 1'b1;
    hz.if_id_flush    = 1'b0;
    hz.id_ex_flush    = 1'b0;
    hz.mem_wb_flush   = 1'b0;
    hz.redirect_valid = 1'b0;
    hz.redirect_pc    = pc_plus4;
    hz.forward_aE     = 2'b00;
    hz.forward_bE     = 2'b00;
    hz.mem_timeout    = timeout_q;

    if (stall) begin
      // EX is frozen, so any mispredict/load-use is re-seen after the stall.
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
      hz.mem_wb_flush = 1'b1;
    end else if (mispredict) begin
      hz.redirect_valid = 1'b1;
      hz.redirect_pc    = hz.actual_takenE ? hz.actual_targetE : pc_plus4;
      hz.if_id_flush    = 1'b1;
      hz.id_ex_flush    = 1'b1;
    end else if (load_use) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.id_ex_flush = 1'b1;
    end

    if (hz.reg_writeM && hz.rdM != 5'd0 && hz.rdM == hz.rs1E) begin
      hz.forward_aE = 2'b10;
    end else if (hz.reg_writeW && hz.rdW != 5'd0 && hz.rdW == hz.rs1E) begin
      hz.forward_aE = 2'b01;
    end
    if (hz.reg_writeM && hz.rdM != 5'd0 && hz.rdM == hz.rs2E) begin
      hz.forward_bE = 2'b10;
    end else if (hz.reg_writeW && hz.rdW != 5'd0 && hz.rdW == hz.rs2E) begin
      hz.forward_bE = 2'b01;
    end

    if (rst) begin
      hz.pc_write       = 1'b0;
      hz.if_id_write    = 1'b0;
      hz.id_ex_write    = 1'b0;
      hz.ex_mem_write   = 1'b0;
      hz.if_id_flush    = 1'b0;
      hz.id_ex_flush    = 1'b0;
      hz.mem_wb_flush   = 1'b0;
      hz.redirect_valid = 1'b0;
      hz.redirect_pc    = 32'd0;
      hz.forward_aE     = 2'b00;
      hz.forward_bE     = 2'b00;
      hz.mem_timeout    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles  <= 32'd0;
      perf_flush_count   <= 32'd0;
      perf_loaduse_count <= 32'd0;
    end else begin
      if (stall && perf_stall_cycles != 32'hFFFF_FFFF) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (!stall && mispredict && perf_flush_count != 32'hFFFF_FFFF) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
      if (!stall && !mispredict && load_use && perf_loaduse_count != 32'hFFFF_FFFF) begin
        perf_loaduse_count <= perf_loaduse_count + 32'd1;
      end
    end
  end
`endif

endmodule
